// File: rtl/miner_comp_pkg.sv
// ============================================================================
// Module : miner_comp_pkg
// Shared FSM encoding, default geometry and index-width helper for the
// multi-lane hash/target comparator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package miner_comp_pkg;

    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_CMP   = 3'd4,
        ST_HIT   = 3'd5
    } state_t;

    // Index width that never collapses to zero bits for single-entry sets.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int HASH_W_DEF     = 256;
    localparam int TGT_WORD_W_DEF = 32;
    localparam int CHUNK_W_DEF    = 64;
    localparam int N_LANES_DEF    = 4;
    localparam int CMP_CHUNKS     = HASH_W_DEF / CHUNK_W_DEF;
    localparam int TGT_WORDS      = HASH_W_DEF / TGT_WORD_W_DEF;
    localparam int LANE_IDX_W     = idx_w(N_LANES_DEF);

endpackage

`default_nettype wire

// File: rtl/rr_lane_arbiter.sv
// ============================================================================
// Module : rr_lane_arbiter
// Combinational pick of the first requesting lane at or after ptr (wrapping).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_lane_arbiter
    import miner_comp_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int IDX_W   = idx_w(N_LANES)
) (
    input  logic [N_LANES-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [N_LANES-1:0] w_rot;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        w_rot     = '0;
        for (int off = N_LANES - 1; off >= 0; off--) begin
            int idx;
            idx = int'(ptr) + off;
            if (idx >= N_LANES) begin
                idx = idx - N_LANES;
            end
            w_rot = req >> idx;
            if (w_rot[0]) begin
                grant_idx = IDX_W'(idx);
                any_grant = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hash_target_comparator_mc.sv
// ============================================================================
// Module : hash_target_comparator_mc
// Round-robin multi-lane hash < target comparator, CHUNK_W bits/cycle MSB-first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hash_target_comparator_mc
    import miner_comp_pkg::*;
#(
    parameter int HASH_W     = 256,
    parameter int TGT_WORD_W = 32,
    parameter int CHUNK_W    = 64,
    parameter int N_LANES    = 4,
    parameter int NONCE_W    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    output logic                         stop_ack,
    input  logic [TGT_WORD_W-1:0]        tgt_word,
    input  logic                         tgt_valid,
    output logic                         tgt_ready,
    input  logic [N_LANES-1:0]           lane_empty,
    output logic [N_LANES-1:0]           lane_re,
    input  logic [N_LANES*HASH_W-1:0]    lane_hash,
    input  logic [N_LANES*NONCE_W-1:0]   lane_nonce,
    output logic                         result_valid,
    output logic [NONCE_W-1:0]           result_nonce,
    output logic [idx_w(N_LANES)-1:0]    result_lane,
    input  logic                         result_ack,
    output logic [31:0]                  hash_cnt
);

    localparam int N_CHUNKS    = HASH_W / CHUNK_W;
    localparam int N_WORDS     = HASH_W / TGT_WORD_W;
    localparam int LANE_W      = idx_w(N_LANES);
    localparam int CHUNK_IDX_W = idx_w(N_CHUNKS);
    localparam int WORD_IDX_W  = idx_w(N_WORDS);

    state_t                  r_state;
    logic [HASH_W-1:0]       r_target;
    logic [WORD_IDX_W-1:0]   r_word;
    logic [CHUNK_IDX_W-1:0]  r_chunk;
    logic [LANE_W-1:0]       r_lane;
    logic [LANE_W-1:0]       r_rr;
    logic                    r_result_valid;
    logic [NONCE_W-1:0]      r_result_nonce;
    logic [LANE_W-1:0]       r_result_lane;
    logic [31:0]             r_hash_cnt;
    logic                    r_idle_flag;

    logic [HASH_W-1:0]       w_hash_arr  [N_LANES];
    logic [NONCE_W-1:0]      w_nonce_arr [N_LANES];
    logic [CHUNK_W-1:0]      w_hash_chunks [N_CHUNKS];
    logic [CHUNK_W-1:0]      w_tgt_chunks  [N_CHUNKS];
    logic [HASH_W-1:0]       w_head_hash;
    logic [CHUNK_W-1:0]      w_hash_chunk;
    logic [CHUNK_W-1:0]      w_tgt_chunk;
    logic                    w_lt;
    logic                    w_gt;
    logic                    w_last;
    logic                    w_cmp_pop;
    logic [LANE_W-1:0]       w_next_rr;
    logic [31:0]             w_cnt_inc;
    logic [LANE_W-1:0]       w_arb_ptr;
    logic [LANE_W-1:0]       w_grant;
    logic                    w_any;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane_unpack
        assign w_hash_arr[g]  = lane_hash[g*HASH_W +: HASH_W];
        assign w_nonce_arr[g] = lane_nonce[g*NONCE_W +: NONCE_W];
    end

    assign w_head_hash = w_hash_arr[r_lane];

    for (genvar c = 0; c < N_CHUNKS; c++) begin : g_chunk_split
        assign w_hash_chunks[c] = w_head_hash[c*CHUNK_W +: CHUNK_W];
        assign w_tgt_chunks[c]  = r_target[c*CHUNK_W +: CHUNK_W];
    end

    assign w_hash_chunk = w_hash_chunks[r_chunk];
    assign w_tgt_chunk  = w_tgt_chunks[r_chunk];
    assign w_lt         = (w_hash_chunk < w_tgt_chunk);
    assign w_gt         = (w_hash_chunk > w_tgt_chunk);
    assign w_last       = (r_chunk == '0);
    // A fully equal hash retires like a miss on its last chunk.
    assign w_cmp_pop    = (r_state == ST_CMP) && !stop && (w_lt || w_gt || w_last);
    assign w_next_rr    = (r_lane == LANE_W'(N_LANES - 1)) ? '0 : r_lane + LANE_W'(1);
    assign w_cnt_inc    = (r_hash_cnt == 32'hFFFF_FFFF) ? r_hash_cnt : r_hash_cnt + 32'd1;

    // Draining always favours the lowest-index lane.
    assign w_arb_ptr = (r_state == ST_DRAIN) ? '0 : r_rr;

    rr_lane_arbiter #(
        .N_LANES (N_LANES),
        .IDX_W   (LANE_W)
    ) u_arb (
        .req       (~lane_empty),
        .ptr       (w_arb_ptr),
        .grant_idx (w_grant),
        .any_grant (w_any)
    );

    always_comb begin
        lane_re = '0;
        if (!rst) begin
            if (r_state == ST_DRAIN && w_any) begin
                lane_re[w_grant] = 1'b1;
            end else if (w_cmp_pop) begin
                lane_re[r_lane] = 1'b1;
            end
        end
    end

    assign tgt_ready    = (r_state == ST_LOAD);
    assign stop_ack     = r_idle_flag && (&lane_empty);
    assign result_valid = r_result_valid;
    assign result_nonce = r_result_nonce;
    assign result_lane  = r_result_lane;
    assign hash_cnt     = r_hash_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_DRAIN;
            r_target       <= '0;
            r_word         <= '0;
            r_chunk        <= '0;
            r_lane         <= '0;
            r_rr           <= '0;
            r_result_valid <= 1'b0;
            r_result_nonce <= '0;
            r_result_lane  <= '0;
            r_hash_cnt     <= '0;
            r_idle_flag    <= 1'b1;
        end else if (stop && r_state != ST_IDLE) begin
            r_state        <= ST_DRAIN;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_DRAIN: begin
                    if (!w_any) begin
                        r_state     <= ST_IDLE;
                        r_idle_flag <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_LOAD;
                        r_word      <= '0;
                        r_hash_cnt  <= '0;
                        r_idle_flag <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (tgt_valid) begin
                        r_target <= {tgt_word, r_target[HASH_W-1:TGT_WORD_W]};
                        if (r_word == WORD_IDX_W'(N_WORDS - 1)) begin
                            r_word  <= '0;
                            r_state <= ST_SCAN;
                        end else begin
                            r_word <= r_word + WORD_IDX_W'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_any) begin
                        r_lane  <= w_grant;
                        r_chunk <= CHUNK_IDX_W'(N_CHUNKS - 1);
                        r_state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (w_lt) begin
                        r_result_valid <= 1'b1;
                        r_result_nonce <= w_nonce_arr[r_lane];
                        r_result_lane  <= r_lane;
                        r_hash_cnt     <= w_cnt_inc;
                        r_state        <= ST_HIT;
                    end else if (w_gt || w_last) begin
                        r_hash_cnt <= w_cnt_inc;
                        r_rr       <= w_next_rr;
                        r_state    <= ST_SCAN;
                    end else begin
                        r_chunk <= r_chunk - CHUNK_IDX_W'(1);
                    end
                end
                ST_HIT: begin
                    if (result_ack) begin
                        r_result_valid <= 1'b0;
                        r_rr           <= w_next_rr;
                        r_state        <= ST_SCAN;
                    end
                end
                default: r_state <= ST_DRAIN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hash_target_comparator_mc.sv
// ============================================================================
// Module : tb_hash_target_comparator_mc
// Self-checking bench: FWFT lane FIFO models plus a queue-based reference.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hash_target_comparator_mc;

    localparam int HASH_W     = 256;
    localparam int TGT_WORD_W = 32;
    localparam int CHUNK_W    = 64;
    localparam int N_LANES    = 4;
    localparam int NONCE_W    = 64;
    localparam int N_WORDS    = HASH_W / TGT_WORD_W;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic                       stop = 1'b0;
    logic                       stop_ack;
    logic [TGT_WORD_W-1:0]      tgt_word = '0;
    logic                       tgt_valid = 1'b0;
    logic                       tgt_ready;
    logic [N_LANES-1:0]         lane_empty = '1;
    logic [N_LANES-1:0]         lane_re;
    logic [N_LANES*HASH_W-1:0]  lane_hash = '0;
    logic [N_LANES*NONCE_W-1:0] lane_nonce = '0;
    logic                       result_valid;
    logic [NONCE_W-1:0]         result_nonce;
    logic [1:0]                 result_lane;
    logic                       result_ack = 1'b0;
    logic [31:0]                hash_cnt;

    always #5 clk = ~clk;

    hash_target_comparator_mc #(
        .HASH_W(HASH_W), .TGT_WORD_W(TGT_WORD_W), .CHUNK_W(CHUNK_W),
        .N_LANES(N_LANES), .NONCE_W(NONCE_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .stop_ack(stop_ack),
        .tgt_word(tgt_word), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .lane_empty(lane_empty), .lane_re(lane_re), .lane_hash(lane_hash),
        .lane_nonce(lane_nonce), .result_valid(result_valid),
        .result_nonce(result_nonce), .result_lane(result_lane),
        .result_ack(result_ack), .hash_cnt(hash_cnt)
    );

    // FIFO contents seen by the DUT and an independent copy for the model.
    logic [HASH_W-1:0]  fq_hash  [N_LANES][$];
    logic [NONCE_W-1:0] fq_nonce [N_LANES][$];
    logic [HASH_W-1:0]  mq_hash  [N_LANES][$];
    logic [NONCE_W-1:0] mq_nonce [N_LANES][$];

    int pop_log[$];
    int multi_pop = 0;
    int checks = 0;
    int errors = 0;

    int               exp_pops[$];
    int               exp_hit_lane[$];
    logic [NONCE_W-1:0] exp_hit_nonce[$];
    int               exp_cnt;
    int               m_rr = 0;
    int               obs_lane[$];
    logic [NONCE_W-1:0] obs_nonce[$];

    localparam logic [HASH_W-1:0] T_MAIN = {32'h0, {224{1'b1}}};

    // FWFT FIFO behaviour: pop on lane_re, present new heads shortly after the edge.
    always @(posedge clk) begin
        logic [N_LANES-1:0] seen;
        seen = lane_re;
        if ($countones(seen) > 1) multi_pop++;
        #1;
        for (int l = 0; l < N_LANES; l++) begin
            if (seen[l]) begin
                pop_log.push_back(l);
                if (fq_hash[l].size() > 0) begin
                    fq_hash[l].delete(0);
                    fq_nonce[l].delete(0);
                end
            end
        end
        for (int l = 0; l < N_LANES; l++) begin
            lane_empty[l] = (fq_hash[l].size() == 0);
            lane_hash[l*HASH_W +: HASH_W]    = lane_empty[l] ? '0 : fq_hash[l][0];
            lane_nonce[l*NONCE_W +: NONCE_W] = lane_empty[l] ? '0 : fq_nonce[l][0];
        end
    end

    function automatic logic [HASH_W-1:0] rand256();
        logic [HASH_W-1:0] v;
        for (int i = 0; i < HASH_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit fifos_empty();
        for (int l = 0; l < N_LANES; l++) if (fq_hash[l].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int q_diff(input int a[$], input int b[$]);
        int d;
        d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
        return d;
    endfunction

    task automatic push(input int l, input logic [HASH_W-1:0] h, input logic [NONCE_W-1:0] n);
        fq_hash[l].push_back(h);
        fq_nonce[l].push_back(n);
        mq_hash[l].push_back(h);
        mq_nonce[l].push_back(n);
    endtask

    // Reference: visit lanes round-robin from the pointer, a hit is a plain hash < target.
    task automatic model_run(input logic [HASH_W-1:0] tgt);
        exp_pops.delete();
        exp_hit_lane.delete();
        exp_hit_nonce.delete();
        exp_cnt = 0;
        forever begin
            int l;
            l = -1;
            for (int off = 0; off < N_LANES; off++)
                if (l < 0 && mq_hash[(m_rr + off) % N_LANES].size() > 0) l = (m_rr + off) % N_LANES;
            if (l < 0) break;
            exp_pops.push_back(l);
            exp_cnt++;
            if (mq_hash[l][0] < tgt) begin
                exp_hit_lane.push_back(l);
                exp_hit_nonce.push_back(mq_nonce[l][0]);
            end
            mq_hash[l].delete(0);
            mq_nonce[l].delete(0);
            m_rr = (l + 1) % N_LANES;
        end
    endtask

    task automatic do_reset();
        start = 0; stop = 0; tgt_valid = 0; result_ack = 0;
        rst = 1;
        for (int l = 0; l < N_LANES; l++) begin
            fq_hash[l].delete(); fq_nonce[l].delete();
            mq_hash[l].delete(); mq_nonce[l].delete();
        end
        repeat (2) @(negedge clk);
        rst = 0;
        m_rr = 0;
        repeat (2) @(negedge clk);
        pop_log.delete();
        multi_pop = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic load_words(input logic [HASH_W-1:0] tgt, input int first, input int last);
        for (int w = first; w <= last; w++) begin
            tgt_word  = tgt[w*TGT_WORD_W +: TGT_WORD_W];
            tgt_valid = 1;
            @(negedge clk);
        end
        tgt_valid = 0;
    endtask

    task automatic wait_rv(output int lat);
        lat = 0;
        while (!result_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Acknowledges every hit as it appears and records it; stops once all quiet.
    task automatic collect(input int budget, output bit timed_out);
        int idle_cnt;
        int cyc;
        idle_cnt = 0;
        cyc = 0;
        obs_lane.delete();
        obs_nonce.delete();
        while (cyc < budget && idle_cnt < 4) begin
            @(negedge clk);
            cyc++;
            if (result_ack) result_ack = 0;
            else if (result_valid) begin
                obs_lane.push_back(int'(result_lane));
                obs_nonce.push_back(result_nonce);
                result_ack = 1;
            end
            if (fifos_empty() && !result_valid && !result_ack) idle_cnt++;
            else idle_cnt = 0;
        end
        result_ack = 0;
        timed_out = (idle_cnt < 4);
    endtask

    task automatic restart_via_stop(output bit timed_out);
        int n;
        stop = 1;
        @(negedge clk);
        stop = 0;
        n = 0;
        while (!(stop_ack && dut.tgt_ready == 1'b0 && fifos_empty()) && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        timed_out = (n >= 50);
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk);
        checks++;
        if (stop_ack !== 1'b1 || result_valid !== 1'b0 || tgt_ready !== 1'b0 ||
            hash_cnt !== 32'd0 || result_nonce !== '0 || result_lane !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: stop_ack=%b rv=%b tgt_ready=%b cnt=%0d nonce=%h lane=%0d, want 1 0 0 0 0 0",
                     stop_ack, result_valid, tgt_ready, hash_cnt, result_nonce, result_lane);
        end
        push(0, rand256(), 64'h1);
        @(negedge clk);
        checks++;
        if (lane_re !== 4'b0000) begin
            errors++;
            $display("FAIL reset_no_pop: lane_re=%b want 0000", lane_re);
        end
        @(negedge clk);
        rst = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (pop_log.size() != 1 || stop_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_drain: pops=%0d stop_ack=%b want 1 1", pop_log.size(), stop_ack);
        end
    endtask

    task automatic test_first_chunk_hit();
        int lat;
        do_reset();
        push(2, {64'h0, rand256() >> 64}, 64'hA5A5_0000_0000_0002);
        pulse_start();
        load_words(T_MAIN, 0, N_WORDS - 1);
        wait_rv(lat);
        repeat (3) @(negedge clk);
        checks++;
        if (lat != 2 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL hit_top_latency: cycles=%0d rv=%b want 2 1", lat, result_valid);
        end
        checks++;
        if (result_lane !== 2'd2 || result_nonce !== 64'hA5A5_0000_0000_0002 || hash_cnt !== 32'd1) begin
            errors++;
            $display("FAIL hit_top_result: lane=%0d nonce=%h cnt=%0d want 2 a5a5000000000002 1",
                     result_lane, result_nonce, hash_cnt);
        end
        checks++;
        if (pop_log.size() != 1 || pop_log[0] != 2 || multi_pop != 0) begin
            errors++;
            $display("FAIL hit_top_pulse: pops=%0d multi=%0d want 1 pop of lane 2", pop_log.size(), multi_pop);
        end
    endtask

    task automatic test_last_chunk();
        int lat;
        do_reset();
        push(1, T_MAIN - 1, 64'h77);
        pulse_start();
        load_words(T_MAIN, 0, N_WORDS - 1);
        wait_rv(lat);
        checks++;
        if (lat != 5 || result_lane !== 2'd1 || result_nonce !== 64'h77) begin
            errors++;
            $display("FAIL hit_last_chunk: cycles=%0d lane=%0d nonce=%h want 5 1 77", lat, result_lane, result_nonce);
        end
        do_reset();
        push(3, T_MAIN, 64'h88);
        pulse_start();
        load_words(T_MAIN, 0, N_WORDS - 1);
        repeat (10) @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || hash_cnt !== 32'd1 || pop_log.size() != 1 || !fifos_empty()) begin
            errors++;
            $display("FAIL equal_no_hit: rv=%b cnt=%0d pops=%0d want 0 1 1", result_valid, hash_cnt, pop_log.size());
        end
    endtask

    task automatic test_round_robin();
        bit to;
        int bad;
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int l = 0; l < N_LANES; l++) push(l, {1'b1, rand256() >> 1}, 64'(k * 16 + l));
        pulse_start();
        load_words(T_MAIN, 0, N_WORDS - 1);
        collect(400, to);
        bad = 0;
        for (int i = 0; i < pop_log.size(); i++) if (pop_log[i] != i % N_LANES) bad++;
        checks++;
        if (to || pop_log.size() != 12 || bad != 0) begin
            errors++;
            $display("FAIL rr_order: timeout=%0d pops=%0d out_of_order=%0d want 0 12 0", to, pop_log.size(), bad);
        end
        checks++;
        if (multi_pop != 0 || obs_lane.size() != 0 || hash_cnt !== 32'd12) begin
            errors++;
            $display("FAIL rr_onehot: multi=%0d hits=%0d cnt=%0d want 0 0 12", multi_pop, obs_lane.size(), hash_cnt);
        end
    endtask

    task automatic test_hit_hold();
        int lat;
        int held_bad;
        int npops;
        bit to;
        logic [HASH_W-1:0] g;
        do_reset();
        g = {1'b1, 255'h0};
        push(0, g, 64'h10); push(0, g, 64'h11);
        push(1, '0, 64'h111); push(1, g, 64'h12);
        push(2, g, 64'h13);
        model_run(T_MAIN);
        pulse_start();
        load_words(T_MAIN, 0, N_WORDS - 1);
        wait_rv(lat);
        checks++;
        if (result_valid !== 1'b1 || result_lane !== 2'd1 || result_nonce !== 64'h111) begin
            errors++;
            $display("FAIL hold_hit: rv=%b lane=%0d nonce=%h want 1 1 111", result_valid, result_lane, result_nonce);
        end
        npops = pop_log.size();
        held_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (result_valid !== 1'b1 || result_lane !== 2'd1 || result_nonce !== 64'h111 || lane_re !== '0) held_bad++;
        end
        checks++;
        if (held_bad != 0 || pop_log.size() != npops) begin
            errors++;
            $display("FAIL hold_stable: bad_cycles=%0d new_pops=%0d want 0 0", held_bad, pop_log.size() - npops);
        end
        result_ack = 1;
        @(negedge clk);
        result_ack = 0;
        collect(200, to);
        checks++;
        if (to || pop_log.size() < 3 || pop_log[2] != 2 || q_diff(pop_log, exp_pops) != 0) begin
            errors++;
            $display("FAIL hold_resume: timeout=%0d pops=%0d third=%0d want 0 %0d 2", to, pop_log.size(),
                     (pop_log.size() > 2) ? pop_log[2] : -1, exp_pops.size());
        end
    endtask

    task automatic test_stop_mid_cmp();
        int n;
        logic [HASH_W-1:0] t6;
        logic [HASH_W-1:0] h6;
        do_reset();
        t6 = {64'h0000_0000_FFFF_FFFF, 64'h8000_0000_0000_0000, 128'h0};
        h6 = {64'h0000_0000_FFFF_FFFF, 64'h9000_0000_0000_0000, 128'h0};
        push(0, h6, 64'h60);
        push(3, rand256(), 64'h63);
        push(3, rand256(), 64'h64);
        pulse_start();
        load_words(t6, 0, N_WORDS - 1);
        repeat (2) @(negedge clk);
        stop = 1;
        #1;
        checks++;
        if (lane_re !== 4'b0000) begin
            errors++;
            $display("FAIL stop_blocks_pop: lane_re=%b want 0000", lane_re);
        end
        @(negedge clk);
        stop = 0;
        checks++;
        if (pop_log.size() != 0 || hash_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stop_no_retire: pops=%0d cnt=%0d want 0 0", pop_log.size(), hash_cnt);
        end
        n = 0;
        while (!(stop_ack && fifos_empty()) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 30 || stop_ack !== 1'b1 || result_valid !== 1'b0 || pop_log.size() != 3 ||
            pop_log[0] != 0 || pop_log[1] != 3 || pop_log[2] != 3) begin
            errors++;
            $display("FAIL stop_drain: cycles=%0d stop_ack=%b rv=%b pops=%0d want <30 1 0 3 (0,3,3)",
                     n, stop_ack, result_valid, pop_log.size());
        end
    endtask

    task automatic test_reset_mid_load();
        int lat;
        do_reset();
        pulse_start();
        load_words(rand256(), 0, 2);
        rst = 1;
        @(negedge clk);
        checks++;
        if (tgt_ready !== 1'b0 || result_valid !== 1'b0 || hash_cnt !== 32'd0 ||
            stop_ack !== 1'b1 || lane_re !== 4'b0000) begin
            errors++;
            $display("FAIL rst_in_load: tgt_ready=%b rv=%b cnt=%0d stop_ack=%b lane_re=%b want 0 0 0 1 0000",
                     tgt_ready, result_valid, hash_cnt, stop_ack, lane_re);
        end
        rst = 0;
        repeat (2) @(negedge clk);
        push(1, 256'h5, 64'h55);
        pulse_start();
        load_words(T_MAIN, 0, N_WORDS - 2);
        repeat (3) @(negedge clk);
        checks++;
        if (tgt_ready !== 1'b1 || result_valid !== 1'b0 || pop_log.size() != 0) begin
            errors++;
            $display("FAIL reload_needs_all: tgt_ready=%b rv=%b pops=%0d want 1 0 0", tgt_ready, result_valid, pop_log.size());
        end
        load_words(T_MAIN, N_WORDS - 1, N_WORDS - 1);
        wait_rv(lat);
        checks++;
        if (lat != 2 || result_lane !== 2'd1 || result_nonce !== 64'h55 || tgt_ready !== 1'b0) begin
            errors++;
            $display("FAIL reload_hit: cycles=%0d lane=%0d nonce=%h tgt_ready=%b want 2 1 55 0",
                     lat, result_lane, result_nonce, tgt_ready);
        end
    endtask

    task automatic test_random();
        bit to;
        logic [HASH_W-1:0] tgt;
        logic [HASH_W-1:0] h;
        int hit_bad;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            restart_via_stop(to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL rand_stop_%0d: no stop_ack within budget", it);
            end
            pop_log.delete();
            tgt = rand256();
            for (int l = 0; l < N_LANES; l++) begin
                int cnt;
                cnt = $urandom_range(0, 4);
                for (int k = 0; k < cnt; k++) begin
                    case ($urandom_range(0, 4))
                        0: h = rand256();
                        1: h = tgt - 1;
                        2: h = tgt;
                        3: h = tgt + 1;
                        default: h = {tgt[HASH_W-1:CHUNK_W], 64'($urandom) << 32 | 64'($urandom)};
                    endcase
                    push(l, h, {32'(it), 32'($urandom)});
                end
            end
            model_run(tgt);
            pulse_start();
            load_words(tgt, 0, N_WORDS - 1);
            collect(2000, to);
            hit_bad = (obs_lane.size() != exp_hit_lane.size()) ? 1 : 0;
            for (int i = 0; i < obs_lane.size() && i < exp_hit_lane.size(); i++)
                if (obs_lane[i] != exp_hit_lane[i] || obs_nonce[i] !== exp_hit_nonce[i]) hit_bad++;
            checks++;
            if (to || q_diff(pop_log, exp_pops) != 0 || hit_bad != 0 || hash_cnt !== 32'(exp_cnt) || multi_pop != 0) begin
                errors++;
                $display("FAIL rand_iter_%0d: timeout=%0d pops=%0d/%0d hits=%0d/%0d hit_diffs=%0d cnt=%0d/%0d multi=%0d",
                         it, to, pop_log.size(), exp_pops.size(), obs_lane.size(), exp_hit_lane.size(),
                         hit_bad, hash_cnt, exp_cnt, multi_pop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_chunk_hit();
        test_last_chunk();
        test_round_robin();
        test_hit_hold();
        test_stop_mid_cmp();
        test_reset_mid_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hash_target_comparator_mc.md
Name: hash_target_comparator_mc

Overview:
Parametrised multi-lane successor of the single-lane hash/target comparator in the oBTC miner datapath. It loads a HASH_W target in TGT_WORD_W words, arbitrates round-robin over N_LANES hash-out FIFOs, and compares each hash against the target MSB-first, CHUNK_W bits per cycle. A hit (hash strictly less than target) reports the hash's nonce and lane, holds them until acknowledged, then resumes scanning. Between heavy_hash lanes and the host result path.

Parameters:
HASH_W, 256, hash/target width
TGT_WORD_W, 32, target load word width; HASH_W % TGT_WORD_W == 0
CHUNK_W, 64, bits compared per cycle; HASH_W % CHUNK_W == 0
N_LANES, 4, number of hash-out FIFOs (1..16)
NONCE_W, 64, nonce width carried alongside each hash

Ports:
clk  in  1  global clock
rst  in  1  synchronous, active-high reset
start  in  1  begin target load (sampled in IDLE)
stop  in  1  abort; return to DRAIN
stop_ack  out  1  high while in IDLE with all lanes empty
tgt_word  in  TGT_WORD_W  target word, least-significant word first
tgt_valid  in  1  tgt_word valid
tgt_ready  out  1  high in LOAD only
lane_empty  in  N_LANES  FWFT FIFO empty flags
lane_re  out  N_LANES  one-hot pop, at most one bit per cycle
lane_hash  in  N_LANES*HASH_W  FWFT head hashes, lane i at [i*HASH_W +: HASH_W]
lane_nonce  in  N_LANES*NONCE_W  FWFT head nonces
result_valid  out  1  hit pending
result_nonce  out  NONCE_W  nonce of hit
result_lane  out  $clog2(N_LANES) (min 1)  lane of hit
result_ack  in  1  consume hit
hash_cnt  out  32  hashes retired since last start, saturating

Behaviour:
- Reset: all outputs 0 except stop_ack=1; target_reg=0, word/chunk counters=0, rr pointer=0, state=DRAIN.
- States: DRAIN, IDLE, LOAD, SCAN, CMP, HIT.
- DRAIN: pop lowest-index non-empty lane each cycle; when all empty -> IDLE. result_valid cleared on entry.
- IDLE: stop_ack=1; start -> LOAD, clears word counter and hash_cnt.
- LOAD: on tgt_valid&tgt_ready, target_reg <= {tgt_word, target_reg[HASH_W-1:TGT_WORD_W]}; after HASH_W/TGT_WORD_W words -> SCAN. Extra words not accepted (tgt_ready=0).
- SCAN: select first non-empty lane at or after rr pointer (wrapping); latch lane, chunk idx = top chunk -> CMP. No lane non-empty: stay.
- CMP: compare chunk idx of lane_hash[lane] vs target_reg, one chunk/cycle, MSB first.
  - hash chunk < target: hit; pop lane, latch nonce/lane, hash_cnt++, -> HIT.
  - hash chunk > target: pop lane, hash_cnt++, rr <= lane+1 (wrap), -> SCAN.
  - equal, not last chunk: idx-- next cycle, no pop.
  - equal on last chunk (hash == target): not a hit; treat as greater.
- Latency per hash: 1 SCAN cycle + 1..HASH_W/CHUNK_W CMP cycles; pop occurs on decision cycle; head must stay stable while in CMP (FWFT guaranteed until pop).
- HIT: result_valid=1, outputs stable; result_ack -> rr <= lane+1, -> SCAN, result_valid=0 next cycle. Other lanes are not popped while in HIT.
- stop in any non-IDLE state has priority over every other event that cycle: no pop issued by compare logic, -> DRAIN; pending hit discarded.
- start outside IDLE ignored. hash_cnt saturates at 2^32-1.
- Reset mid-operation returns all state to reset values in one cycle; no pop in reset cycle.

Decomposition:
- Package miner_comp_pkg: state enum, CMP_CHUNKS = HASH_W/CHUNK_W, TGT_WORDS = HASH_W/TGT_WORD_W, LANE_IDX_W.
- Sub-module rr_lane_arbiter: N_LANES request vector + pointer -> grant index and any-grant, combinational; reused by DRAIN with pointer forced to 0.

Test Plan:
- Load target 0x0000_0000_FFFF_...FF (8 words); lane 2 hash top chunk 0 -> result_valid, result_lane=2, hit after 1 CMP cycle, lane_re[2] single pulse.
- Hash equal to target on chunks 3..1, chunk 0 one below -> hit after 4 CMP cycles; hash exactly equal -> no hit, popped, hash_cnt=1.
- All 4 lanes hold greater hashes -> pops ordered 0,1,2,3,0..., never two lane_re bits same cycle.
- Hit pending, lanes 0/1 non-empty, no ack for 20 cycles -> no pops; ack -> next scan starts at lane+1.
- stop asserted in CMP mid-chunk -> no compare pop that cycle, DRAIN empties all lanes, stop_ack=1 in IDLE.
- rst asserted during LOAD after 3 words -> next start needs all 8 words again; outputs at reset values.
